// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Op-code and FSM encodings shared by the ALU control decoder
//               and the execute-stage ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SLL   = 4'b0011,
        OP_SUB   = 4'b0110,
        OP_PASSB = 4'b1000
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational single-cycle ALU datapath. SLL is included only
//               when ALU_BARREL_SHIFT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]              operation,
    input  logic [XLEN-1:0]         op_a,
    input  logic [XLEN-1:0]         op_b,
`ifdef ALU_BARREL_SHIFT_EN
    input  logic [$clog2(XLEN)-1:0] shamt,
`endif
    output logic [XLEN-1:0]         result
);

    always_comb begin
        result = '0;
        case (operation)
            OP_AND:   result = op_a & op_b;
            OP_OR:    result = op_a | op_b;
            OP_ADD:   result = op_a + op_b;
            OP_SUB:   result = op_a - op_b;
            OP_PASSB: result = op_b;
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL:   result = op_a << shamt;
`endif
            // Unrecognised codes are legal and produce zero.
            default:  result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU with valid/ready handshakes; SLL iterates one
//               bit per cycle unless ALU_BARREL_SHIFT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      operation,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    alu_state_e        state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic [XLEN-1:0]   core_result;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = op_b[SHAMT_W-1:0];

    alu_core #(.XLEN(XLEN)) u_core (
        .operation (operation),
        .op_a      (op_a),
        .op_b      (op_b),
`ifdef ALU_BARREL_SHIFT_EN
        .shamt     (shamt),
`endif
        .result    (core_result)
    );

`ifndef ALU_BARREL_SHIFT_EN
    logic [XLEN-1:0]    shreg_q, shreg_d;
    logic [SHAMT_W-1:0] count_q, count_d;
`endif

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
`ifndef ALU_BARREL_SHIFT_EN
        shreg_d  = shreg_q;
        count_d  = count_q;
`endif
        if (flush) begin
            state_d = IDLE;
`ifndef ALU_BARREL_SHIFT_EN
            count_d = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
                        if (operation == OP_SLL) begin
                            shreg_d = op_a;
                            count_d = shamt;
                            if (shamt == '0) begin
                                result_d = op_a;
                                state_d  = DONE;
                            end else begin
                                state_d  = SHIFT;
                            end
                        end else begin
                            result_d = core_result;
                            state_d  = DONE;
                        end
`else
                        result_d = core_result;
                        state_d  = DONE;
`endif
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    shreg_d = shreg_q << 1;
                    count_d = count_q - SHAMT_W'(1);
                    // Last step: publish the shifted value in the same cycle.
                    if (count_q == SHAMT_W'(1)) begin
                        result_d = shreg_q << 1;
                        state_d  = DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

`ifndef ALU_BARREL_SHIFT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            count_q <= '0;
        end else begin
            shreg_q <= shreg_d;
            count_q <= count_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit against a behavioural
//               model of results and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  operation = 4'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_res = 32'd0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0011: return a << b[4:0];
            4'b1000: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        if (op == 4'b0011 && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
        return 1;
`endif
    endfunction

    // Present one op and hold it until the accepting edge, then scramble inputs.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        operation = op; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; operation = 4'($urandom); op_a = $urandom; op_b = $urandom;
    endtask

    task automatic wait_result(output int lat, output bit rdy_seen);
        lat = 0; rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready && !out_valid) rdy_seen = 1'b1;
        end while (!out_valid && lat < 100);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Runs one op end to end, checking latency, result and zero.
    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        int lat; bit rdy; logic [31:0] exp;
        exp = model_res(op, a, b);
        send(op, a, b);
        wait_result(lat, rdy);
        checks++;
        if (lat !== model_lat(op, b)) begin
            failures++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, model_lat(op, b));
        end
        checks++;
        if (result !== exp || zero !== (exp == 32'd0)) begin
            failures++; $display("FAIL %s result got=%h/%b exp=%h/%b", nm, result, zero, exp, exp == 32'd0);
        end
        checks++;
        if (rdy) begin
            failures++; $display("FAIL %s in_ready got=1 exp=0 while busy", nm);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result !== exp) begin
                failures++; $display("FAIL %s stall%0d got=%b/%h exp=1/%h", nm, i, out_valid, result, exp);
            end
        end
        consume();
        last_res = exp;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (result !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL reset got res=%h zero=%b ov=%b ir=%b exp=0/1/0/1", result, zero, out_valid, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_cycle();
        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 0);
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 0);
        run_op("or", 4'b0001, $urandom, $urandom, 0);
        run_op("and", 4'b0000, $urandom, $urandom, 0);
    endtask

    task automatic test_sll();
        run_op("sll31", 4'b0011, 32'd1, 32'd31, 0);
        run_op("sll_hi_ignored", 4'b0011, 32'h0000_ABCD, 32'h20, 0);
        run_op("sll7", 4'b0011, 32'h8000_00F1, 32'd7, 0);
    endtask

    task automatic test_backpressure();
        run_op("passb_bp", 4'b1000, $urandom, 32'h1234_5000, 5);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release got ir=%b ov=%b exp=1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        int lat; logic [31:0] hold;
        lat = model_lat(4'b0011, 32'd10);
        hold = (lat <= 3) ? model_res(4'b0011, 32'h3, 32'd10) : last_res;
        send(4'b0011, 32'h3, 32'd10);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (k >= lat)) begin
                failures++; $display("FAIL flush_pre%0d out_valid got=%b exp=%b", k, out_valid, k >= lat);
            end
        end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; operation = 4'b1000; op_b = 32'hDEAD_BEEF;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== hold || zero !== (hold == 32'd0)) begin
            failures++; $display("FAIL flush_post got ov=%b ir=%b res=%h exp=0/1/%h", out_valid, in_ready, result, hold);
        end
        last_res = hold;
        lat = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        checks++;
        if (lat != 0) begin
            failures++; $display("FAIL flush_quiet out_valid cycles got=%0d exp=0", lat);
        end
        run_op("and_after_flush", 4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 0);
    endtask

    task automatic test_unknown();
        run_op("unknown_f", 4'b1111, $urandom | 32'h1, $urandom, 0);
        run_op("unknown_4", 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    endtask

    task automatic test_async_reset();
        send(4'b0011, 32'd1, 32'd20);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL async_reset got res=%h zero=%b ov=%b ir=%b exp=0/1/0/1", result, zero, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_res = 32'd0;
    endtask

    task automatic test_random();
        logic [3:0] ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011, 4'b1000, 4'b1111, 4'b0101};
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            a = (n % 5 == 0) ? 32'd0 : $urandom;
            b = (n % 7 == 0) ? a : $urandom;
            run_op($sformatf("rand%0d", n), ops[$urandom_range(0, 7)], a, b, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_sll();
        test_backpressure();
        test_flush();
        test_unknown();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
